// File: rtl/contador_axil_slave.sv
// AXI4-Lite slave for the counter IP: CTRL/PRESCALE/LIMIT/COUNT register map
// driving a prescaled up-counter with a programmable wrap limit and wrap irq.
module contador_axil_slave #(
  parameter int          C_DATA_WIDTH  = 32,
  parameter int          C_ADDR_WIDTH  = 4,
  parameter logic [31:0] C_RESET_LIMIT = 32'hFFFF_FFFF
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                AWPROT,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [C_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                ARPROT,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [C_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [C_DATA_WIDTH-1:0]   count_o,
  output logic                      irq_o
);

  localparam int DW = C_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [DW-1:0] ONE = 1;

  logic          aw_rdy, ar_rdy;
  logic          en, wrap;
  logic [DW-1:0] prescale, limit, count, presc;
  logic [DW-1:0] rd_mux;

  logic       wr_hs, rd_hs;
  logic [1:0] wsel, rsel;
  logic       wr_ctrl, wr_presc, wr_limit, wr_count;
  logic       en_next, tick, hit, wrap_evt;

  logic unused;
  assign unused = ^{AWPROT, ARPROT, AWADDR, ARADDR};

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  assign AWREADY = aw_rdy;
  assign WREADY  = aw_rdy;
  assign ARREADY = ar_rdy;
  assign BRESP   = 2'b00;
  assign RRESP   = 2'b00;
  assign count_o = count;

  // Valids are held by the master, so ready-high with both valids is the handshake.
  assign wr_hs    = aw_rdy & AWVALID & WVALID;
  assign rd_hs    = ar_rdy & ARVALID;
  assign wsel     = AWADDR[3:2];
  assign rsel     = ARADDR[3:2];
  assign wr_ctrl  = wr_hs && (wsel == 2'd0);
  assign wr_presc = wr_hs && (wsel == 2'd1);
  assign wr_limit = wr_hs && (wsel == 2'd2);
  assign wr_count = wr_hs && (wsel == 2'd3);

  assign en_next  = (wr_ctrl && WSTRB[0]) ? WDATA[0] : en;
  assign tick     = en && (presc == prescale);
  assign hit      = (count == limit);
  assign wrap_evt = tick && hit && !wr_count;

  always_comb begin
    rd_mux = '0;
    case (rsel)
      2'd0: rd_mux = {{(DW-9){1'b0}}, wrap, 7'b0, en};
      2'd1: rd_mux = prescale;
      2'd2: rd_mux = limit;
      default: rd_mux = count;
    endcase
  end

  // Write channel: one outstanding write, ready pulses for a single cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_rdy <= 1'b0;
      BVALID <= 1'b0;
    end else begin
      aw_rdy <= !aw_rdy && AWVALID && WVALID && !BVALID;
      if (wr_hs)
        BVALID <= 1'b1;
      else if (BREADY)
        BVALID <= 1'b0;
    end
  end

  // Read channel: RDATA captured at the handshake, held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ar_rdy <= 1'b0;
      RVALID <= 1'b0;
      RDATA  <= '0;
    end else begin
      ar_rdy <= !ar_rdy && ARVALID && !RVALID;
      if (rd_hs) begin
        RVALID <= 1'b1;
        RDATA  <= rd_mux;
      end else if (RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en       <= 1'b0;
      prescale <= '0;
      limit    <= C_RESET_LIMIT;
    end else begin
      en <= en_next;
      if (wr_presc) prescale <= merge(prescale, WDATA, WSTRB);
      if (wr_limit) limit    <= merge(limit, WDATA, WSTRB);
    end
  end

  // Set of WRAP has priority over a same-edge write-1-to-clear.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      wrap <= 1'b0;
    else if (wrap_evt)
      wrap <= 1'b1;
    else if (wr_ctrl && WSTRB[1] && WDATA[8])
      wrap <= 1'b0;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      presc <= '0;
    else if (wr_ctrl && !en_next)
      presc <= '0;
    else if (en)
      presc <= tick ? '0 : presc + ONE;
  end

  // COUNT above LIMIT never matches, so it rolls over at 2^32 without WRAP.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      count <= '0;
      irq_o <= 1'b0;
    end else begin
      irq_o <= wrap_evt;
      if (wr_count)
        count <= merge(count, WDATA, WSTRB);
      else if (tick)
        count <= hit ? '0 : count + ONE;
    end
  end

endmodule

// File: tb/tb_contador_axil_slave.sv
// Directed bench for contador_axil_slave: register access, counting, wrap irq,
// byte strobes, backpressure and asynchronous reset mid-transaction.
module tb_contador_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, irq_o;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, count_o;

  int errors = 0;
  int checks = 0;

  contador_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .count_o(count_o), .irq_o(irq_o)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!AWREADY && n < 50);
    chk("wr_accept", {30'b0, AWREADY, WREADY}, 32'h3);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    BREADY = 1'b1;
    wr_issue(a, d, s);
    chk("bvalid", BVALID, 1);
    chk("bresp", BRESP, 0);
    @(posedge ACLK); #1;
  endtask

  task automatic rd_issue(input logic [3:0] a);
    int n;
    ARADDR = a; ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!ARREADY && n < 50);
    chk("rd_accept", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    RREADY = 1'b1;
    rd_issue(a);
    chk("rvalid", RVALID, 1);
    chk("rresp", RRESP, 0);
    d = RDATA;
    @(posedge ACLK); #1;
  endtask

  initial begin
    logic [31:0] rd, v;
    logic [31:0] seq [4];
    int n;
    bit aw_done, ar_done, aw_hs, ar_hs;

    ARESET = 1'b1;
    AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    WDATA = '0; WSTRB = '0;
    #12;
    chk("rst_awready", AWREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_count", count_o, 0);
    chk("rst_irq", irq_o, 0);
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Basic register access.
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'h0, rd); chk("ctrl_rd", rd, 32'h1);
    axi_read(4'h4, rd); chk("presc_rd", rd, 32'h2);
    axi_read(4'h8, rd); chk("limit_rd", rd, 32'h3);
    axi_read(4'hC, rd); chk("count_ge4", rd >= 32'd4, 1);

    // Wrap at LIMIT=3 with tick every cycle.
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'h0, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h0, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    n = 0;
    do begin @(negedge ACLK); n++; end while (count_o !== 32'd1 && n < 20);
    chk("count_first", count_o, 1);
    seq = '{32'd2, 32'd3, 32'd0, 32'd1};
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("count_seq", count_o, seq[i]);
      chk("irq_seq", irq_o, (seq[i] == 0) ? 1 : 0);
    end
    @(posedge ACLK); #1;
    axi_read(4'h0, rd); chk("ctrl_wrap", rd, 32'h101);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    axi_write(4'h0, 32'h100, 4'b0010);
    axi_read(4'h0, rd); chk("ctrl_w1c", rd, 32'h001);

    // Prescale of 4: one increment every 5 cycles.
    axi_write(4'h4, 32'h4, 4'hF);
    v = count_o;
    n = 0;
    do begin @(negedge ACLK); n++; end while (count_o === v && n < 20);
    chk("presc_moved", (count_o == v + 1) ? 1 : 0, 1);
    v = count_o;
    repeat (4) @(negedge ACLK);
    chk("presc_hold", count_o, v);
    @(negedge ACLK);
    chk("presc_step", count_o, v + 1);
    @(posedge ACLK); #1;

    // Byte strobes on LIMIT.
    axi_write(4'h8, 32'h0, 4'hF);
    axi_write(4'h8, 32'hAABB_CCDD, 4'b0010);
    axi_read(4'h8, rd); chk("limit_strb", rd, 32'h0000_CC00);
    axi_write(4'h0, 32'h0, 4'hF);

    // Backpressure on both response channels.
    BREADY = 1'b0; RREADY = 1'b0;
    AWADDR = 4'h4; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 4'h8; ARVALID = 1;
    aw_done = 0; ar_done = 0; n = 0;
    while (!(aw_done && ar_done) && n < 50) begin
      @(negedge ACLK);
      aw_hs = AWREADY && AWVALID;
      ar_hs = ARREADY && ARVALID;
      @(posedge ACLK); #1;
      if (aw_hs) begin AWVALID = 0; WVALID = 0; aw_done = 1; end
      if (ar_hs) begin ARVALID = 0; ar_done = 1; end
      n++;
    end
    chk("bp_both_accepted", {30'b0, aw_done, ar_done}, 32'h3);
    AWADDR = 4'h4; WDATA = 32'h66; AWVALID = 1; WVALID = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("bp_bvalid", BVALID, 1);
      chk("bp_rvalid", RVALID, 1);
      chk("bp_rdata", RDATA, 32'h0000_CC00);
      chk("bp_no_accept", AWREADY, 0);
    end
    BREADY = 1; RREADY = 1;
    wr_issue(4'h4, 32'h66, 4'hF);
    chk("bp_second_b", BVALID, 1);
    @(posedge ACLK); #1;
    axi_read(4'h4, rd); chk("bp_second_data", rd, 32'h66);

    // Reset in the middle of a write response.
    axi_write(4'hC, 32'h7, 4'hF);
    BREADY = 0;
    wr_issue(4'h4, 32'h9, 4'hF);
    @(negedge ACLK);
    chk("pre_rst_bvalid", BVALID, 1);
    chk("pre_rst_count", count_o, 7);
    #2 ARESET = 1'b1;
    #1;
    chk("mid_rst_ready", {29'b0, AWREADY, WREADY, ARREADY}, 0);
    chk("mid_rst_bvalid", BVALID, 0);
    chk("mid_rst_rvalid", RVALID, 0);
    chk("mid_rst_count", count_o, 0);
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;
    axi_read(4'h8, rd); chk("post_rst_limit", rd, 32'hFFFF_FFFF);
    axi_read(4'h0, rd); chk("post_rst_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); chk("post_rst_presc", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
